// File: rtl/read_fsm.sv
// read_fsm: read-path PHY state machine (preamble detect, burst capture, CRC check, postamble)
module read_fsm #(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_enable,
  input  logic           i_rd_en,
  input  logic [1:0]     i_burstlength,
  input  logic           i_crc_en,
  input  logic [1:0]     i_DQS,
  input  logic [2*N-1:0] i_DQ,
  input  logic [2*N-1:0] i_crc_code,
  output logic [2*N-1:0] o_rddata,
  output logic           o_rddata_valid,
  output logic [2*N-1:0] o_crc_data,
  output logic           o_crc_enable,
  output logic           o_crc_error,
  output logic           o_timeout_error,
  output logic [2:0]     o_fsm_state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PRE  = 3'd1,
    PREAMBLE  = 3'd2,
    DATA      = 3'd3,
    PAD8      = 3'd4,
    CRC_CHK   = 3'd5,
    POSTAMBLE = 3'd6
  } state_t;
  state_t         state, state_n;
  logic [4:0]     to_cnt, to_cnt_n;
  logic           pre_cnt, pre_cnt_n;
  logic [2:0]     beat, beat_n, last;
  logic           pend, pend_n, bl8, bl8_n, crc, crc_n;
  logic [2*N-1:0] rddata_q, rddata_n;
  logic           valid_q, valid_n, crc_err_q, crc_err_n, to_err_q, to_err_n;
  // state, counters and registered outputs; reset aborts any burst at once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      pre_cnt   <= 1'b0;
      beat      <= '0;
      pend      <= 1'b0;
      bl8       <= 1'b0;
      crc       <= 1'b0;
      rddata_q  <= '0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state     <= state_n;
      to_cnt    <= to_cnt_n;
      pre_cnt   <= pre_cnt_n;
      beat      <= beat_n;
      pend      <= pend_n;
      bl8       <= bl8_n;
      crc       <= crc_n;
      rddata_q  <= rddata_n;
      valid_q   <= valid_n;
      crc_err_q <= crc_err_n;
      to_err_q  <= to_err_n;
    end
  end
  // next-state and CRC feed; everything holds while disabled
  always_comb begin
    state_n    = state;
    to_cnt_n   = to_cnt;
    pre_cnt_n  = pre_cnt;
    beat_n     = beat;
    pend_n     = pend;
    bl8_n      = bl8;
    crc_n      = crc;
    rddata_n   = rddata_q;
    valid_n    = 1'b0;
    crc_err_n  = 1'b0;
    to_err_n   = 1'b0;
    o_crc_data = '0;
    o_crc_enable = 1'b0;
    last       = bl8 ? 3'd3 : 3'd7;
    if (i_enable) begin
      if (i_rd_en && state >= WAIT_PRE && state <= CRC_CHK) pend_n = 1'b1;
      case (state)
        IDLE: if (i_rd_en) begin
          bl8_n    = (i_burstlength == 2'b01);
          crc_n    = i_crc_en;
          to_cnt_n = '0;
          state_n  = WAIT_PRE;
        end
        WAIT_PRE: if (i_DQS == 2'b01) begin
          pre_cnt_n = 1'b1;
          state_n   = PREAMBLE;
        end else begin
          to_cnt_n = to_cnt + 5'd1;
          if (to_cnt == 5'd30) begin
            to_err_n = 1'b1;
            pend_n   = 1'b0;
            state_n  = IDLE;
          end
        end
        PREAMBLE: begin
          pre_cnt_n = 1'b0;
          beat_n    = '0;
          state_n   = (i_DQS == 2'b01 && pre_cnt) ? DATA : WAIT_PRE;
        end
        DATA: begin
          o_crc_data   = crc ? i_DQ : '0;
          o_crc_enable = crc;
          rddata_n     = i_DQ;
          valid_n      = 1'b1;
          beat_n       = beat + 3'd1;
          if (beat == last) begin
            beat_n  = '0;
            state_n = !crc ? POSTAMBLE : bl8 ? PAD8 : CRC_CHK;
          end
        end
        PAD8: begin
          o_crc_data   = '1;
          o_crc_enable = 1'b1;
          beat_n       = beat + 3'd1;
          if (beat == 3'd3) begin
            beat_n  = '0;
            state_n = CRC_CHK;
          end
        end
        CRC_CHK: begin
          crc_err_n = (i_DQ != i_crc_code);
          state_n   = POSTAMBLE;
        end
        POSTAMBLE: if (pend || i_rd_en) begin
          bl8_n    = (i_burstlength == 2'b01);
          crc_n    = i_crc_en;
          pend_n   = 1'b0;
          to_cnt_n = '0;
          state_n  = WAIT_PRE;
        end else state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  assign o_rddata        = rddata_q;
  assign o_rddata_valid  = valid_q & i_enable;
  assign o_crc_error     = crc_err_q & i_enable;
  assign o_timeout_error = to_err_q & i_enable;
  assign o_fsm_state     = state;
endmodule

// File: tb/tb_read_fsm.sv
// tb_read_fsm: directed scoreboard bench for read_fsm
module tb_read_fsm;
  localparam int N = 4;
  logic           i_clk, i_rst, i_enable, i_rd_en, i_crc_en;
  logic [1:0]     i_burstlength, i_DQS;
  logic [2*N-1:0] i_DQ, i_crc_code;
  logic [2*N-1:0] o_rddata, o_crc_data;
  logic           o_rddata_valid, o_crc_enable, o_crc_error, o_timeout_error;
  logic [2:0]     o_fsm_state;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  logic [7:0] sb[$];

  read_fsm #(.N(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_rd_en(i_rd_en),
    .i_burstlength(i_burstlength), .i_crc_en(i_crc_en), .i_DQS(i_DQS),
    .i_DQ(i_DQ), .i_crc_code(i_crc_code), .o_rddata(o_rddata),
    .o_rddata_valid(o_rddata_valid), .o_crc_data(o_crc_data),
    .o_crc_enable(o_crc_enable), .o_crc_error(o_crc_error),
    .o_timeout_error(o_timeout_error), .o_fsm_state(o_fsm_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid beat must match the oldest beat driven
  always @(negedge i_clk) begin
    if (i_rst && o_rddata_valid) begin
      vcnt++;
      if (sb.size() == 0) chk("unexpected_valid", 32'(o_rddata), 32'hFFFF_FFFF);
      else chk("rddata", 32'(o_rddata), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [2:0] exp);
    chk(tag, 32'(o_fsm_state), 32'(exp));
  endtask

  task automatic rd(input logic [1:0] bl, input logic c);
    i_rd_en = 1'b1;
    i_burstlength = bl;
    i_crc_en = c;
    tick();
    i_rd_en = 1'b0;
    st("rd_to_wait_pre", 3'd1);
  endtask

  task automatic pre();
    i_DQS = 2'b01;
    tick();
    st("preamble1", 3'd2);
    tick();
    st("preamble2_data", 3'd3);
    chk("valid_before_beat", 32'(o_rddata_valid), 32'd0);
  endtask

  task automatic burst(input int n, input logic [7:0] base, input logic c);
    for (int i = 0; i < n; i++) begin
      i_DQS = 2'b10;
      i_DQ = base + 8'(i);
      sb.push_back(i_DQ);
      #1;
      chk("data_crc_en", 32'(o_crc_enable), 32'(c));
      chk("data_crc_data", 32'(o_crc_data), c ? 32'(i_DQ) : 32'd0);
      tick();
    end
    i_DQS = 2'b00;
  endtask

  initial begin
    i_rst = 1'b0; i_enable = 1'b1; i_rd_en = 1'b0; i_crc_en = 1'b0;
    i_burstlength = 2'b10; i_DQS = 2'b00; i_DQ = '0; i_crc_code = '0;
    tick(); tick();
    st("reset_state", 3'd0);
    chk("reset_valid", 32'(o_rddata_valid), 32'd0);
    chk("reset_rddata", 32'(o_rddata), 32'd0);
    chk("reset_crc_en", 32'(o_crc_enable), 32'd0);
    chk("reset_errs", {30'd0, o_crc_error, o_timeout_error}, 32'd0);
    i_rst = 1'b1;
    tick();
    st("idle_after_reset", 3'd0);
    // BL16 without CRC
    vcnt = 0;
    rd(2'b10, 1'b0);
    pre();
    burst(8, 8'h00, 1'b0);
    st("bl16_postamble", 3'd6);
    tick();
    st("bl16_idle", 3'd0);
    chk("bl16_valid_count", 32'(vcnt), 32'd8);
    // BL16 with CRC, matching code
    rd(2'b10, 1'b1);
    pre();
    burst(8, 8'h10, 1'b1);
    st("crc_chk_state", 3'd5);
    i_DQ = 8'hA5; i_crc_code = 8'hA5;
    #1;
    chk("crc_chk_en_low", 32'(o_crc_enable), 32'd0);
    tick();
    st("crc_ok_post", 3'd6);
    chk("crc_ok_no_err", 32'(o_crc_error), 32'd0);
    tick();
    chk("crc_ok_no_err2", 32'(o_crc_error), 32'd0);
    st("crc_ok_idle", 3'd0);
    // BL16 with CRC, mismatching code
    rd(2'b11, 1'b1);
    pre();
    burst(8, 8'h50, 1'b1);
    st("crc_bad_chk", 3'd5);
    i_DQ = 8'hA4;
    tick();
    chk("crc_bad_pulse", 32'(o_crc_error), 32'd1);
    tick();
    chk("crc_bad_pulse_end", 32'(o_crc_error), 32'd0);
    st("crc_bad_idle", 3'd0);
    // BL8 with CRC: four beats then four pad cycles
    vcnt = 0;
    rd(2'b01, 1'b1);
    pre();
    burst(4, 8'h70, 1'b1);
    for (int i = 0; i < 4; i++) begin
      st("pad8_state", 3'd4);
      i_DQ = 8'h3C;
      #1;
      chk("pad8_crc_data", 32'(o_crc_data), 32'hFF);
      chk("pad8_crc_en", 32'(o_crc_enable), 32'd1);
      tick();
    end
    st("bl8_crc_chk", 3'd5);
    i_DQ = 8'h5A; i_crc_code = 8'h5A;
    tick();
    st("bl8_post", 3'd6);
    tick();
    st("bl8_idle", 3'd0);
    chk("bl8_valid_count", 32'(vcnt), 32'd4);
    chk("bl8_no_crc_err", 32'(o_crc_error), 32'd0);
    // timeout with DQS idle
    rd(2'b10, 1'b0);
    for (int i = 1; i < 31; i++) begin
      tick();
      if (o_fsm_state !== 3'd1 || o_timeout_error !== 1'b0) chk("timeout_early", {28'd0, o_timeout_error, o_fsm_state}, 32'd1);
    end
    tick();
    chk("timeout_pulse", 32'(o_timeout_error), 32'd1);
    st("timeout_idle", 3'd0);
    tick();
    chk("timeout_pulse_end", 32'(o_timeout_error), 32'd0);
    // a lone preamble cycle falls back to WAIT_PRE
    vcnt = 0;
    rd(2'b01, 1'b0);
    i_DQS = 2'b01;
    tick();
    st("lone_pre", 3'd2);
    i_DQS = 2'b00;
    tick();
    st("lone_pre_back", 3'd1);
    chk("lone_pre_no_valid", 32'(o_rddata_valid), 32'd0);
    pre();
    burst(4, 8'h60, 1'b0);
    st("lone_post", 3'd6);
    tick();
    st("lone_idle", 3'd0);
    chk("lone_valid_count", 32'(vcnt), 32'd4);
    // back-to-back read queued during DATA, third request dropped
    vcnt = 0;
    rd(2'b10, 1'b0);
    pre();
    for (int i = 0; i < 8; i++) begin
      i_DQS = 2'b10;
      i_DQ = 8'h40 + 8'(i);
      sb.push_back(i_DQ);
      i_rd_en = (i == 2 || i == 4);
      tick();
    end
    i_rd_en = 1'b0; i_DQS = 2'b00;
    st("b2b_post", 3'd6);
    tick();
    st("b2b_wait_pre", 3'd1);
    pre();
    burst(8, 8'h80, 1'b0);
    st("b2b_post2", 3'd6);
    tick();
    st("b2b_dropped_idle", 3'd0);
    chk("b2b_valid_count", 32'(vcnt), 32'd16);
    // reset in the middle of a burst
    rd(2'b10, 1'b0);
    pre();
    burst(3, 8'h20, 1'b0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    st("midreset_state", 3'd0);
    chk("midreset_valid", 32'(o_rddata_valid), 32'd0);
    chk("midreset_rddata", 32'(o_rddata), 32'd0);
    chk("midreset_errs", {30'd0, o_crc_error, o_timeout_error}, 32'd0);
    i_rst = 1'b1;
    tick();
    st("midreset_idle", 3'd0);
    // fresh BL8 CRC read with a one-cycle disable inside DATA
    vcnt = 0;
    rd(2'b01, 1'b1);
    pre();
    burst(2, 8'h30, 1'b1);
    @(negedge i_clk);
    #1;
    i_enable = 1'b0; i_DQS = 2'b10; i_DQ = 8'hEE;
    #1;
    chk("dis_crc_en", 32'(o_crc_enable), 32'd0);
    chk("dis_valid", 32'(o_rddata_valid), 32'd0);
    tick();
    st("dis_hold", 3'd3);
    chk("dis_valid_reg", 32'(o_rddata_valid), 32'd0);
    i_enable = 1'b1;
    burst(2, 8'h32, 1'b1);
    st("fresh_pad8", 3'd4);
    tick(); tick(); tick(); tick();
    st("fresh_crc_chk", 3'd5);
    i_DQ = 8'h11; i_crc_code = 8'h11;
    tick();
    tick();
    st("fresh_idle", 3'd0);
    chk("fresh_no_crc_err", 32'(o_crc_error), 32'd0);
    chk("fresh_valid_count", 32'(vcnt), 32'd4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_fsm.md
# read_fsm

Read-path counterpart of the PHY write state machine. It sits between the DQ/DQS capture stage and the frequency-ratio block. After a read command it:
- detects the read preamble on the sampled DQS pair;
- collects the data burst (BL8 or BL16) and forwards it upstream;
- feeds the CRC block, and when CRC is enabled compares the received CRC beat against the locally generated code;
- runs the postamble, with single-depth queuing of a back-to-back read.

## Interface
Parameters
- N, 4, DRAM device width. DQ carries 2N bits per PHY clock (two UIs).

Ports
- i_clk  in  1  PHY clock.
- i_rst  in  1  Asynchronous, active-low reset.
- i_enable  in  1  Block enable. When low, state, counters and the pending flag hold, and all valid, enable and pulse outputs are forced to 0.
- i_rd_en  in  1  Read-issued pulse from the frequency-ratio block.
- i_burstlength  in  2  2'b01 = BL8; any other value = BL16. Sampled when leaving IDLE or POSTAMBLE.
- i_crc_en  in  1  DRAM appends one CRC beat. Sampled together with i_burstlength.
- i_DQS  in  2  Sampled strobe pair: 2'b00 idle/postamble, 2'b01 preamble, 2'b10 toggling data.
- i_DQ  in  2N  Sampled data pair.
- i_crc_code  in  2N  Code from the CRC block. Must be valid in the CRC_CHK cycle.
- o_rddata  out  2N  Captured read data, registered.
- o_rddata_valid  out  1  o_rddata qualifier.
- o_crc_data  out  2N  Data to the CRC block (combinational).
- o_crc_enable  out  1  CRC block accumulate enable (combinational).
- o_crc_error  out  1  One-cycle pulse on CRC mismatch.
- o_timeout_error  out  1  One-cycle pulse when no preamble arrives.
- o_fsm_state  out  3  Current state encoding.

## Operation
- States and encodings:
  - IDLE 000
  - WAIT_PRE 001
  - PREAMBLE 010
  - DATA 011
  - PAD8 100
  - CRC_CHK 101
  - POSTAMBLE 110
  - Encoding 111 is illegal and goes to IDLE.
- IDLE: on i_rd_en, latch bl8 = (i_burstlength == 2'b01) and crc = i_crc_en, then go to WAIT_PRE.
- WAIT_PRE: 5-bit timeout counter, cleared on entry.
  - i_DQS == 2'b01 → PREAMBLE, with the preamble counter set to 1.
  - Counter reaches 31 with no preamble → o_timeout_error pulse, clear the pending flag, go to IDLE.
- PREAMBLE: requires two consecutive cycles of 2'b01.
  - i_DQS == 2'b01 with the count at 1 → DATA.
  - Any other i_DQS → back to WAIT_PRE; the timeout counter is not cleared.
- DATA: beat counter runs 0..7 for BL16, 0..3 for BL8.
  - Each cycle: o_crc_data = i_DQ and o_crc_enable = 1 (only when crc = 1); i_DQ is registered into o_rddata.
  - Last beat with crc = 0 → POSTAMBLE.
  - Last beat with crc = 1 and BL16 → CRC_CHK.
  - Last beat with crc = 1 and BL8 → PAD8.
- PAD8: 4 cycles with o_crc_data = all ones and o_crc_enable = 1. i_DQ is ignored and no read data is produced. Then → CRC_CHK.
- CRC_CHK: one cycle, o_crc_enable = 0. If i_DQ != i_crc_code, o_crc_error pulses in the next cycle. Then → POSTAMBLE.
- POSTAMBLE: one cycle; i_DQS is not checked.
  - Pending flag set (or i_rd_en high this cycle) → WAIT_PRE, re-latching bl8 and crc, clearing the flag.
  - Otherwise → IDLE.
- Back-to-back reads:
  - i_rd_en in WAIT_PRE through CRC_CHK sets the single pending flag.
  - A further i_rd_en while the flag is already set is dropped.
- Outside the DATA and PAD8 states, o_crc_enable = 0 and o_crc_data = 0.

## Timing
- Reset values: state IDLE; all counters and the pending flag 0; o_rddata = 0; o_rddata_valid, o_crc_error and o_timeout_error = 0.
- Reset asserted mid-burst aborts immediately. No error pulse is produced.
- Latency:
  - o_rddata and o_rddata_valid follow the DATA sample by 1 cycle.
  - A burst yields exactly 8 (BL16) or 4 (BL8) consecutive valid cycles.
  - o_crc_error is registered 1 cycle after CRC_CHK.
- Minimum read-to-read spacing: i_rd_en in the last DATA cycle with crc = 0 gives POSTAMBLE → WAIT_PRE in the next cycle.
- i_rd_en in IDLE is acted on in the same cycle; the next state is WAIT_PRE.
- Deasserting i_enable during DATA:
  - The beat counter stalls and o_rddata_valid is 0 for that cycle.
  - The beats sampled while disabled are lost. This is intended: the upstream stage also stalls.
- o_fsm_state is combinational from the state register.

## Test plan
- BL16, crc = 0, i_DQS = 01, 01, then 8× 10 with i_DQ = 8'h00..8'h07 → o_rddata_valid high for 8 cycles starting 1 cycle after the first beat, data 00..07 in order, then POSTAMBLE, then IDLE.
- BL16, crc = 1, i_DQ CRC beat equal to i_crc_code = 8'hA5 → o_crc_error stays 0. Repeat with CRC beat 8'hA4 → one o_crc_error pulse, the cycle after CRC_CHK.
- BL8, crc = 1 → 4 valid beats, then 4 PAD8 cycles with o_crc_data = 8'hFF and o_crc_enable = 1, then CRC_CHK, then POSTAMBLE.
- i_rd_en with i_DQS held at 00 → o_timeout_error pulse exactly 31 cycles after WAIT_PRE entry, then state 000. Also: a single 01 followed by 00 → returns to WAIT_PRE with no data.
- Second i_rd_en during DATA → after POSTAMBLE, state goes directly to 001 and the second burst is captured. A third i_rd_en while pending is dropped.
- i_rst low at DATA beat 3 → all outputs 0 and state 000 immediately. After release, a fresh read completes normally.
